zuma_cfg_loader: RTL

ZUMA_CFG_LOADER -- requirements
Module: zuma_cfg_loader

---
 rtl/zuma_cfg_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/zuma_cfg_loader.sv
// Configuration loader for a ZUMA-style overlay: streams N words into the overlay
// configuration memory, pulses the overlay virtual reset, then reports done.
module zuma_cfg_loader #(
    parameter int LUT_SIZE     = 6,
    parameter int NUM_STAGES   = 1,
    parameter int CONFIG_WIDTH = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int VRST_CYCLES  = 1,
    parameter int AUTO_START   = 1,
    parameter int REVERSE_BITS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    cfg_valid,
    input  logic [CONFIG_WIDTH-1:0] cfg_data,
    input  logic                    cfg_last,
    output logic                    cfg_ready,
    output logic                    config_en,
    output logic [CONFIG_WIDTH-1:0] config_data,
    output logic [ADDR_WIDTH-1:0]   config_addr,
    output logic                    ffrst,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int N  = (2 ** LUT_SIZE) * NUM_STAGES;
    localparam int KW = $clog2(N) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, VRST, RUN} state_t;

    state_t                  state_reg;
    logic [KW-1:0]           k_reg;
    logic [7:0]              vrst_cnt_reg;
    logic                    auto_pending_reg;
    logic [CONFIG_WIDTH-1:0] word_ordered;
    logic                    handshake;
    logic                    go;

    // Overlay shift chains expect the word MSB-first relative to the source.
    generate
        if (REVERSE_BITS != 0) begin : g_rev
            for (genvar gi = 0; gi < CONFIG_WIDTH; gi++) begin : g_bit
                assign word_ordered[CONFIG_WIDTH-1-gi] = cfg_data[gi];
            end
        end else begin : g_pass
            assign word_ordered = cfg_data;
        end
    endgenerate

    assign cfg_ready = (state_reg == LOAD);
    assign busy      = (state_reg == LOAD) || (state_reg == VRST);
    assign handshake = cfg_valid && cfg_ready;
    // A pending auto-start behaves exactly like a start pulse in IDLE.
    assign go        = start || auto_pending_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            k_reg            <= '0;
            vrst_cnt_reg     <= '0;
            auto_pending_reg <= (AUTO_START != 0);
            config_en        <= 1'b0;
            config_data      <= '0;
            config_addr      <= '0;
            ffrst            <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            config_en <= 1'b0;
            case (state_reg)
                IDLE, RUN: begin
                    if (go) begin
                        state_reg        <= LOAD;
                        k_reg            <= '0;
                        done             <= 1'b0;
                        error            <= 1'b0;
                        auto_pending_reg <= 1'b0;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        config_en   <= 1'b1;
                        config_data <= word_ordered;
                        config_addr <= ADDR_WIDTH'(k_reg);
                        k_reg       <= k_reg + KW'(1);
                        if (cfg_last && (k_reg == K_LAST)) begin
                            state_reg    <= VRST;
                            ffrst        <= 1'b1;
                            vrst_cnt_reg <= 8'(VRST_CYCLES - 1);
                        end else if (cfg_last || (k_reg == K_LAST)) begin
                            // Length mismatch: the stream does not fit the overlay.
                            state_reg <= IDLE;
                            error     <= 1'b1;
                        end
                    end
                end
                VRST: begin
                    if (vrst_cnt_reg == 8'd0) begin
                        state_reg <= RUN;
                        ffrst     <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        vrst_cnt_reg <= vrst_cnt_reg - 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
